phase_spike_decoder: RTL

Receiver side of the gamma phase code. It samples the global gamma phase and the cycle_start pulse, and latches the phase of the first spike on each channel within each gamma cycle. It then converts that latency back into an 8-bit intensity (earlier spike means a stronger value). At each cycle boundary it publishes one result word per cycle on a valid/ready interface to downstream attention/readout logic.

---
 rtl/phase_spike_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/phase_spike_decoder.sv
// Gamma phase-code receiver: latches first-spike phase per channel over each
// gamma window and publishes 255-phase intensities on a valid/ready port.

module phase_spike_lane #(
  parameter logic [7:0] NO_SPIKE_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       open,
  input  logic       acq,
  input  logic       spike,
  input  logic [7:0] phase,
  output logic [7:0] val,
  output logic       seen,
  output logic       multi
);
  logic [7:0] cap_q, cap_d;
  logic       seen_q, seen_d;
  logic       multi_q, multi_d;

  always_comb begin
    cap_d   = cap_q;
    seen_d  = seen_q;
    multi_d = multi_q;
    if (open) begin
      // A spike in the cycle_start clock is phase 0 of the new window.
      seen_d  = spike;
      cap_d   = spike ? phase : 8'd0;
      multi_d = 1'b0;
    end else if (acq && spike) begin
      if (seen_q) begin
        multi_d = 1'b1;
      end else begin
        seen_d = 1'b1;
        cap_d  = phase;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= 8'd0;
      seen_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      seen_q  <= seen_d;
      multi_q <= multi_d;
    end
  end

  assign val   = seen_q ? (8'd255 - cap_q) : NO_SPIKE_VAL;
  assign seen  = seen_q;
  assign multi = multi_q;
endmodule

module phase_spike_decoder #(
  parameter int         N_CH         = 4,
  parameter logic [7:0] NO_SPIKE_VAL = 8'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        phase_in,
  input  logic              cycle_start,
  input  logic [N_CH-1:0]   spike_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*N_CH-1:0] out_data,
  output logic [N_CH-1:0]   out_mask,
  output logic [N_CH-1:0]   out_multi,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  typedef enum logic {IDLE, ACQ} state_t;

  state_t                 state_q, state_d;
  logic [N_CH-1:0][7:0]   lane_val;
  logic [N_CH-1:0]        lane_seen, lane_multi;
  logic                   acq, close, load, drop;

  logic                   out_valid_q, out_valid_d;
  logic [N_CH-1:0][7:0]   out_data_q, out_data_d;
  logic [N_CH-1:0]        out_mask_q, out_mask_d;
  logic [N_CH-1:0]        out_multi_q, out_multi_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;

  assign acq   = (state_q == ACQ);
  assign close = acq && cycle_start;
  // A pending word that is being accepted this edge frees the slot.
  assign load  = close && (!out_valid_q || out_ready);
  assign drop  = close && out_valid_q && !out_ready;

  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_lane
      phase_spike_lane #(.NO_SPIKE_VAL(NO_SPIKE_VAL)) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .open  (cycle_start),
        .acq   (acq),
        .spike (spike_in[k]),
        .phase (phase_in),
        .val   (lane_val[k]),
        .seen  (lane_seen[k]),
        .multi (lane_multi[k])
      );
    end
  endgenerate

  always_comb begin
    state_d     = cycle_start ? ACQ : state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_multi_d = out_multi_q;
    overflow_d  = drop;
    drop_cnt_d  = drop_cnt_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_val;
      out_mask_d  = lane_seen;
      out_multi_d = lane_multi;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_multi_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_multi_q <= out_multi_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_multi = out_multi_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
endmodule
